vga_pattern_stage: RTL and testbench

- Pixel-generation stage directly downstream of the XVGA timing generator.
- Consumes hcount/vcount/hsync/vsync/blank and produces 12-bit RGB (4:4:4) plus delayed sync/blank, aligned for the DAC/VGA pins.
- Selectable test patterns include a bouncing box.
- Box position and direction update once per frame.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pattern_stage_if.sv | 38 +++
 rtl/vga_pattern_stage_box_mover.sv | 76 +++++++
 rtl/vga_pattern_stage.sv | 149 ++++++++++++++
 tb/tb_vga_pattern_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA pattern stage:
//   rgb12_t   - 12-bit 4:4:4 RGB pixel {r[3:0], g[3:0], b[3:0]}
//   pattern_e - test pattern selector (bars, checker, box, grid)
//   dir_e     - box movement direction per axis
//   WHITE/BLACK colour constants and the colour-bar helper.
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef logic [11:0] rgb12_t;

   typedef enum logic [1:0] {
      PAT_BARS    = 2'd0,
      PAT_CHECKER = 2'd1,
      PAT_BOX     = 2'd2,
      PAT_GRID    = 2'd3
   } pattern_e;

   typedef enum logic {
      INC = 1'b0,
      DEC = 1'b1
   } dir_e;

   localparam rgb12_t WHITE = 12'hFFF;
   localparam rgb12_t BLACK = 12'h000;

   // Each index bit drives one full colour channel: bit2 = red, bit1 = green,
   // bit0 = blue, giving the classic eight saturated bars.
   function automatic rgb12_t bar_color(input logic [2:0] idx);
      return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
   endfunction

endpackage

// File: rtl/vga_pattern_stage_if.sv
// -----------------------------------------------------------------------------
// vga_pattern_stage_if
// Bundle between the XVGA timing generator and the pattern stage, plus the
// stage's pin-side outputs.
//   hcount_in/vcount_in      - current pixel / line
//   hsync_in/vsync_in        - active-low syncs
//   blank_in                 - high outside the active area
//   mode_in                  - pattern select
//   pixel_out                - 12-bit RGB to the DAC
//   hsync_out/vsync_out/blank_out - syncs and blank realigned with pixel_out
//   frame_count_out          - frames since reset (wraps)
// Modports: master = timing side (drives *_in), slave = pattern stage.
// -----------------------------------------------------------------------------
interface vga_pattern_stage_if;

   logic [11:0] hcount_in;
   logic [10:0] vcount_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        blank_in;
   logic [1:0]  mode_in;
   logic [11:0] pixel_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        blank_out;
   logic [15:0] frame_count_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, blank_in, mode_in,
      input  pixel_out, hsync_out, vsync_out, blank_out, frame_count_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in, mode_in,
      output pixel_out, hsync_out, vsync_out, blank_out, frame_count_out
   );

endinterface

// File: rtl/vga_pattern_stage_box_mover.sv
// -----------------------------------------------------------------------------
// box_mover
// One axis of the bouncing box: a position register and an INC/DEC direction
// FSM. Advances one step each time step_en is high (once per frame) and
// bounces off 0 and LIMIT - BOX_SIZE.
// Ports:
//   vclock_in - pixel clock
//   reset_in  - synchronous active-high reset (pos = 0, direction INC)
//   step_en   - one-cycle frame-start pulse
//   pos_o     - current box edge position on this axis
// -----------------------------------------------------------------------------
module box_mover
   import vga_pkg::*;
#(
   parameter int LIMIT    = 1024,
   parameter int WIDTH    = 12,
   parameter int BOX_SIZE = 64,
   parameter int SPEED    = 4
) (
   input  logic             vclock_in,
   input  logic             reset_in,
   input  logic             step_en,
   output logic [WIDTH-1:0] pos_o
);

   localparam logic [0:0] ST_INC = 1'(INC);
   localparam logic [0:0] ST_DEC = 1'(DEC);

   // Two spare bits keep pos + BOX_SIZE + SPEED from wrapping before the
   // comparison against LIMIT.
   localparam int RW = WIDTH + 2;

   logic [WIDTH-1:0] pos_q, pos_d;
   logic [0:0]       state_q, state_d;
   logic [RW-1:0]    reach;

   // NOTE: every always_comb output gets a default on entry so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      pos_d   = pos_q;
      state_d = state_q;
      reach   = RW'(pos_q) + RW'(BOX_SIZE + SPEED);
      if (step_en) begin
         if (state_q == ST_INC) begin
            if (reach >= RW'(LIMIT)) begin
               pos_d   = WIDTH'(LIMIT - BOX_SIZE);
               state_d = ST_DEC;
            end else begin
               pos_d = pos_q + WIDTH'(SPEED);
            end
         end else begin
            if (pos_q <= WIDTH'(SPEED)) begin
               pos_d   = '0;
               state_d = ST_INC;
            end else begin
               pos_d = pos_q - WIDTH'(SPEED);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge vclock_in) begin
      if (reset_in) begin
         pos_q   <= '0;
         state_q <= ST_INC;
      end else begin
         pos_q   <= pos_d;
         state_q <= state_d;
      end
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/vga_pattern_stage.sv
// -----------------------------------------------------------------------------
// vga_pattern_stage
// Pixel generator downstream of the XVGA timing generator. Produces one of
// four test patterns (colour bars, checkerboard, bouncing box, grid) with a
// fixed 2-cycle latency and realigns hsync/vsync/blank to match.
// Ports:
//   vclock_in - pixel clock
//   reset_in  - synchronous active-high reset
//   vga       - vga_pattern_stage_if.slave (timing inputs, pixel/sync outputs)
// Pipeline:
//   stage 1 - pattern colour, syncs and blank registered
//   stage 2 - blank-masked pixel, syncs and blank registered to the pins
// Frame start is the vsync falling edge (registered vsync high, input low);
// it bumps the frame counter, latches the pattern select and steps the box.
// Optional: define VGA_PATTERN_CROSSHAIR_EN to overlay a white 1-pixel
// crosshair through the screen centre.
// -----------------------------------------------------------------------------
module vga_pattern_stage
   import vga_pkg::*;
#(
   parameter int     DISPLAY_WIDTH  = 1024,
   parameter int     DISPLAY_HEIGHT = 768,
   parameter int     BOX_SIZE       = 64,
   parameter int     SPEED          = 4,
   parameter rgb12_t BOX_COLOR      = 12'hF00,
   parameter rgb12_t BG_COLOR       = 12'h003
) (
   input  logic                 vclock_in,
   input  logic                 reset_in,
   vga_pattern_stage_if.slave   vga
);

   localparam int XW = 12;
   localparam int YW = 11;

   logic          frame_start;
   logic [XW-1:0] box_x;
   logic [YW-1:0] box_y;
   logic [XW:0]   box_x_end;
   logic [YW:0]   box_y_end;
   logic          box_hit;

   pattern_e      active_mode_q, active_mode_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [15:0]   frame_out_q;
   rgb12_t        pat_q, pat_d;
   rgb12_t        pixel_q, pixel_d;
   logic          hs_d1_q, vs_d1_q, bl_d1_q;
   logic          hs_d2_q, vs_d2_q, bl_d2_q;

   // The stage-1 vsync tap doubles as the previous-cycle vsync.
   assign frame_start = vs_d1_q & ~vga.vsync_in;

   box_mover #(
      .LIMIT    (DISPLAY_WIDTH),
      .WIDTH    (XW),
      .BOX_SIZE (BOX_SIZE),
      .SPEED    (SPEED)
   ) u_box_x (
      .vclock_in (vclock_in),
      .reset_in  (reset_in),
      .step_en   (frame_start),
      .pos_o     (box_x)
   );

   box_mover #(
      .LIMIT    (DISPLAY_HEIGHT),
      .WIDTH    (YW),
      .BOX_SIZE (BOX_SIZE),
      .SPEED    (SPEED)
   ) u_box_y (
      .vclock_in (vclock_in),
      .reset_in  (reset_in),
      .step_en   (frame_start),
      .pos_o     (box_y)
   );

   // Box extent is computed one bit wider so box + BOX_SIZE never wraps.
   always_comb begin
      box_x_end = {1'b0, box_x} + (XW+1)'(BOX_SIZE);
      box_y_end = {1'b0, box_y} + (YW+1)'(BOX_SIZE);
      box_hit   = (vga.hcount_in >= box_x) && ({1'b0, vga.hcount_in} < box_x_end) &&
                  (vga.vcount_in >= box_y) && ({1'b0, vga.vcount_in} < box_y_end);
   end

   // Stage-1 colour uses the mode and box position in force before any
   // frame-start update on this edge.
   always_comb begin
      pat_d = BLACK;
      case (active_mode_q)
         PAT_BARS:    pat_d = bar_color(vga.hcount_in[9:7]);
         PAT_CHECKER: pat_d = (vga.hcount_in[5] ^ vga.vcount_in[5]) ? WHITE : BLACK;
         PAT_BOX:     pat_d = box_hit ? BOX_COLOR : BG_COLOR;
         PAT_GRID:    pat_d = ((vga.hcount_in[5:0] == 6'd0) || (vga.vcount_in[5:0] == 6'd0))
                              ? WHITE : BLACK;
         default:     pat_d = BLACK;
      endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
      if (((vga.hcount_in == XW'(DISPLAY_WIDTH / 2)) ||
           (vga.vcount_in == YW'(DISPLAY_HEIGHT / 2))) &&
          (vga.hcount_in < XW'(DISPLAY_WIDTH)) &&
          (vga.vcount_in < YW'(DISPLAY_HEIGHT))) begin
         pat_d = WHITE;
      end
`endif
   end

   always_comb begin
      active_mode_d = frame_start ? pattern_e'(vga.mode_in) : active_mode_q;
      frame_cnt_d   = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
      // Blank masks in stage 2 using the blank sampled with the same pixel.
      pixel_d       = bl_d1_q ? BLACK : pat_q;
   end

   always_ff @(posedge vclock_in) begin
      if (reset_in) begin
         active_mode_q <= PAT_BARS;
         frame_cnt_q   <= '0;
         frame_out_q   <= '0;
         pat_q         <= BLACK;
         pixel_q       <= BLACK;
         hs_d1_q       <= 1'b1;
         vs_d1_q       <= 1'b1;
         bl_d1_q       <= 1'b1;
         hs_d2_q       <= 1'b1;
         vs_d2_q       <= 1'b1;
         bl_d2_q       <= 1'b1;
      end else begin
         active_mode_q <= active_mode_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_out_q   <= frame_cnt_q;
         pat_q         <= pat_d;
         pixel_q       <= pixel_d;
         hs_d1_q       <= vga.hsync_in;
         vs_d1_q       <= vga.vsync_in;
         bl_d1_q       <= vga.blank_in;
         hs_d2_q       <= hs_d1_q;
         vs_d2_q       <= vs_d1_q;
         bl_d2_q       <= bl_d1_q;
      end
   end

   assign vga.pixel_out       = pixel_q;
   assign vga.hsync_out       = hs_d2_q;
   assign vga.vsync_out       = vs_d2_q;
   assign vga.blank_out       = bl_d2_q;
   assign vga.frame_count_out = frame_out_q;

endmodule

// File: tb/tb_vga_pattern_stage.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_stage
// Self-checking bench for vga_pattern_stage. A behavioural model computes
// every pixel from the pattern rules, the box position as a closed-form
// triangle wave of the frame number, and the 2-cycle output latency; a
// compare process checks all outputs every cycle. Directed probes pin the
// model with hand-computed values, then randomized traffic (including
// mid-frame mode changes and resets) runs against the model.
// Define VGA_PATTERN_CROSSHAIR_EN for both RTL and bench to test the overlay.
// -----------------------------------------------------------------------------
module tb_vga_pattern_stage;
   import vga_pkg::*;

   localparam int     DW   = 1024;
   localparam int     DH   = 768;
   localparam int     BOX  = 64;
   localparam int     SPD  = 4;
   localparam rgb12_t BOXC = 12'hF00;
   localparam rgb12_t BGC  = 12'h003;

   typedef struct packed {
      logic [11:0] pix;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [15:0] fc;
   } out_t;

   localparam out_t RST_OUT = {12'h000, 1'b1, 1'b1, 1'b1, 16'h0000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_pattern_stage_if vif ();

   vga_pattern_stage dut (
      .vclock_in (clk),
      .reset_in  (rst),
      .vga       (vif)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Box edge after n frame starts: bounces linearly between 0 and
   // limit - BOX in steps of SPD (peak is a multiple of SPD for both axes).
   function automatic int box_pos(input int n, input int limit);
      int half;
      int m;
      half = (limit - BOX) / SPD;
      m    = n % (2 * half);
      return (m <= half) ? SPD * m : SPD * (2 * half - m);
   endfunction

   function automatic logic [11:0] pattern(input logic [1:0] mode, input int h, input int v,
                                           input int bx, input int by);
      logic [11:0] c;
      int idx;
      idx = (h / 128) % 8;
      case (mode)
         2'd0: c = (((idx & 4) != 0) ? 12'hF00 : 12'h000) |
                   (((idx & 2) != 0) ? 12'h0F0 : 12'h000) |
                   (((idx & 1) != 0) ? 12'h00F : 12'h000);
         2'd1: c = (((h / 32) % 2) != ((v / 32) % 2)) ? 12'hFFF : 12'h000;
         2'd2: c = (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? BOXC : BGC;
         default: c = ((h % 64) == 0 || (v % 64) == 0) ? 12'hFFF : 12'h000;
      endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
      if ((h == DW / 2 || v == DH / 2) && h < DW && v < DH) c = 12'hFFF;
`endif
      return c;
   endfunction

   // ---------------- behavioural model ----------------
   out_t        s1, s2;
   int          nframes;
   logic [15:0] cnt;
   logic        vs_prev;
   logic [1:0]  mode_act;
   logic        model_valid = 1'b0;
   logic        fs_m;

   assign fs_m = vs_prev & ~vif.vsync_in;

   always @(posedge clk) begin
      if (rst) begin
         s1          <= RST_OUT;
         s2          <= RST_OUT;
         nframes     <= 0;
         cnt         <= 16'd0;
         vs_prev     <= 1'b1;
         mode_act    <= 2'd0;
         model_valid <= 1'b1;
      end else begin
         s2     <= s1;
         s1.pix <= vif.blank_in ? 12'h000
                   : pattern(mode_act, int'(vif.hcount_in), int'(vif.vcount_in),
                             box_pos(nframes, DW), box_pos(nframes, DH));
         s1.hs  <= vif.hsync_in;
         s1.vs  <= vif.vsync_in;
         s1.bl  <= vif.blank_in;
         s1.fc  <= fs_m ? cnt + 16'd1 : cnt;
         if (fs_m) begin
            nframes  <= nframes + 1;
            cnt      <= cnt + 16'd1;
            mode_act <= vif.mode_in;
         end
         vs_prev <= vif.vsync_in;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_valid) begin
         check("pixel_out", 32'(vif.pixel_out), 32'(s2.pix));
         check("hsync_out", 32'(vif.hsync_out), 32'(s2.hs));
         check("vsync_out", 32'(vif.vsync_out), 32'(s2.vs));
         check("blank_out", 32'(vif.blank_out), 32'(s2.bl));
         check("frame_count_out", 32'(vif.frame_count_out), 32'(s2.fc));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_start(input logic [1:0] m);
      vif.mode_in  = m;
      vif.vsync_in = 1'b1;
      tick();
      vif.vsync_in = 1'b0;
      tick();
   endtask

   task automatic probe(input string name, input int h, input int v, input logic [11:0] exp);
      vif.hcount_in = 12'(h);
      vif.vcount_in = 11'(v);
      vif.blank_in  = 1'b0;
      tick(2);
      check(name, 32'(vif.pixel_out), 32'(exp));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bx;
      int by;
      vif.hcount_in = '0;
      vif.vcount_in = '0;
      vif.hsync_in  = 1'b1;
      vif.vsync_in  = 1'b1;
      vif.blank_in  = 1'b1;
      vif.mode_in   = 2'd0;

      // Reset for 3 cycles, then one post-reset cycle still shows reset values.
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick();
      check("rst_pixel", 32'(vif.pixel_out), 32'h000);
      check("rst_hsync", 32'(vif.hsync_out), 32'h1);
      check("rst_vsync", 32'(vif.vsync_out), 32'h1);
      check("rst_blank", 32'(vif.blank_out), 32'h1);
      check("rst_frame", 32'(vif.frame_count_out), 32'h0);

      // Colour bars: h=300 -> bar 2 (green), h=400 -> bar 3, h=640 -> bar 5.
      frame_start(2'd0);
      tick();
      check("frame_after_one", 32'(vif.frame_count_out), 32'd1);
      probe("bar2", 300, 100, 12'h0F0);
      probe("bar3", 400, 100, 12'h0FF);
      probe("bar5", 640, 100, 12'hF0F);

      // hsync edge appears exactly two cycles later.
      vif.hsync_in = 1'b0;
      tick();
      check("hsync_lat1", 32'(vif.hsync_out), 32'h1);
      tick();
      check("hsync_lat2", 32'(vif.hsync_out), 32'h0);
      vif.hsync_in = 1'b1;
      tick(2);
      check("hsync_back", 32'(vif.hsync_out), 32'h1);

      // Box: the frame start that latches mode 2 also steps the box to (4,4).
      pulse_reset();
      frame_start(2'd2);
      probe("box_in", 10, 10, 12'hF00);
      probe("box_right_out", 68, 10, 12'h003);
      probe("box_left_out", 3, 10, 12'h003);
      probe("box_corner_in", 67, 67, 12'hF00);
      probe("box_below_out", 10, 68, 12'h003);

      // After 240 frames x = 960 (y = 448); frame 241: x = 956 (y = 444).
      repeat (239) frame_start(2'd2);
      probe("bounce_240_left", 960, 500, 12'hF00);
      probe("bounce_240_before", 959, 500, 12'h003);
      probe("bounce_240_right", 1023, 500, 12'hF00);
      check("frame_240", 32'(vif.frame_count_out), 32'd240);
      frame_start(2'd2);
      probe("bounce_241_left", 956, 500, 12'hF00);
      probe("bounce_241_before", 955, 500, 12'h003);
      probe("bounce_241_right", 1020, 500, 12'h003);
      check("frame_241", 32'(vif.frame_count_out), 32'd241);

      // Mid-frame mode change waits for the next frame start.
      frame_start(2'd1);
      probe("checker", 32, 1, 12'hFFF);
      vif.mode_in = 2'd3;
      probe("mode_hold", 32, 1, 12'hFFF);
      frame_start(2'd3);
      probe("grid_off", 32, 1, 12'h000);
      probe("grid_line", 64, 5, 12'hFFF);

      // Centre column: crosshair overlay when enabled, plain checker otherwise.
      frame_start(2'd1);
`ifdef VGA_PATTERN_CROSSHAIR_EN
      probe("crosshair", 512, 200, 12'hFFF);
`else
      probe("no_crosshair", 512, 200, 12'h000);
`endif
      vif.blank_in = 1'b1;
      tick(2);
      check("centre_blanked", 32'(vif.pixel_out), 32'h000);

      // Randomized traffic against the model.
      for (int i = 0; i < 6000; i++) begin
         bx = box_pos(nframes, DW);
         by = box_pos(nframes, DH);
         case ($urandom_range(0, 3))
            0: begin
               vif.hcount_in = 12'(bx + int'($urandom_range(0, 68)));
               vif.vcount_in = 11'(by + int'($urandom_range(0, 68)));
            end
            1: begin
               vif.hcount_in = ($urandom_range(0, 1) == 0) ? 12'd512 : 12'($urandom_range(0, 1343));
               vif.vcount_in = ($urandom_range(0, 1) == 0) ? 11'd384 : 11'($urandom_range(0, 805));
            end
            default: begin
               vif.hcount_in = 12'($urandom_range(0, 1343));
               vif.vcount_in = 11'($urandom_range(0, 805));
            end
         endcase
         vif.blank_in = (vif.hcount_in >= 12'd1024) || (vif.vcount_in >= 11'd768) ||
                        ($urandom_range(0, 15) == 0);
         vif.hsync_in = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) vif.vsync_in = ~vif.vsync_in;
         if ($urandom_range(0, 20) == 0) vif.mode_in = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
